// File: rtl/e_mdu_pkg.sv
// Shared MDU op-code encodings and the combinational multiply/divide datapath of the E-stage MDU.
package e_mdu_pkg;

    localparam int unsigned MduOpW = 3;

    // mult only acts alongside E_MDU_start, so it can share the idle encoding.
    localparam logic [MduOpW-1:0] MDU_NONE  = 3'd0;
    localparam logic [MduOpW-1:0] MDU_MULT  = 3'd0;
    localparam logic [MduOpW-1:0] MDU_MULTU = 3'd1;
    localparam logic [MduOpW-1:0] MDU_DIV   = 3'd2;
    localparam logic [MduOpW-1:0] MDU_DIVU  = 3'd3;
    localparam logic [MduOpW-1:0] MDU_MFHI  = 3'd4;
    localparam logic [MduOpW-1:0] MDU_MFLO  = 3'd5;
    localparam logic [MduOpW-1:0] MDU_MTHI  = 3'd6;
    localparam logic [MduOpW-1:0] MDU_MTLO  = 3'd7;

    typedef struct packed {
        logic        commit;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

    function automatic logic is_arith(input logic [MduOpW-1:0] op);
        return op <= MDU_DIVU;
    endfunction

    function automatic logic is_div(input logic [MduOpW-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic mdu_res_t mdu_compute(input logic [MduOpW-1:0] op,
                                             input logic [31:0]       a,
                                             input logic [31:0]       b);
        mdu_res_t    res;
        logic [63:0] prod;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        res    = '0;
        prod   = '0;
        mag_a  = '0;
        mag_b  = '0;
        quo    = '0;
        rem    = '0;
        res.commit = 1'b1;
        case (op)
            MDU_MULT: begin
                prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MDU_MULTU: begin
                prod   = {32'd0, a} * {32'd0, b};
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MDU_DIV: begin
                if (b == 32'd0) begin
                    res.commit = 1'b0;
                end else begin
                    // Divide magnitudes, then restore signs; 0x8000_0000 / -1 falls out naturally.
                    mag_a  = a[31] ? neg32(a) : a;
                    mag_b  = b[31] ? neg32(b) : b;
                    quo    = mag_a / mag_b;
                    rem    = mag_a % mag_b;
                    res.lo = (a[31] ^ b[31]) ? neg32(quo) : quo;
                    res.hi = a[31] ? neg32(rem) : rem;
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    res.commit = 1'b0;
                end else begin
                    res.lo = a / b;
                    res.hi = a % b;
                end
            end
            default: res.commit = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div, HI/LO registers, mfhi/mflo/mthi/mtlo.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              E_MDU_start,
    input  logic [MduOpW-1:0] E_MDU_op,
    input  logic [31:0]       E_MDU_A,
    input  logic [31:0]       E_MDU_B,
    output logic              E_MDU_busy,
    output logic [31:0]       E_MDU_out
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [MduOpW-1:0] op_q, op_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    mdu_res_t          res;
    logic              start_ok;
    logic              commit;

    assign E_MDU_busy = (cnt_q != '0);
    assign start_ok   = E_MDU_start && !E_MDU_busy && is_arith(E_MDU_op);
    assign res        = mdu_compute(op_q, a_q, b_q);
    assign commit     = (cnt_q == CntW'(1)) && res.commit;

    always_comb begin
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        if (E_MDU_busy) begin
            cnt_d = cnt_q - CntW'(1);
        end else if (start_ok) begin
            a_d   = E_MDU_A;
            b_d   = E_MDU_B;
            op_d  = E_MDU_op;
            cnt_d = is_div(E_MDU_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
        end
    end

    // Commit only happens while busy, so it never collides with an mthi/mtlo write.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = res.hi;
            lo_d = res.lo;
        end else if (!E_MDU_busy) begin
            if (E_MDU_op == MDU_MTHI) begin
                hi_d = E_MDU_A;
            end else if (E_MDU_op == MDU_MTLO) begin
                lo_d = E_MDU_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign E_MDU_out = (E_MDU_op == MDU_MFHI) ? hi_q :
                       (E_MDU_op == MDU_MFLO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_e_mdu.sv
// Randomised and directed bench for e_mdu against a plain-arithmetic HI/LO model.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        E_MDU_start = 1'b0;
    logic [2:0]  E_MDU_op = 3'd0;
    logic [31:0] E_MDU_A = 32'd0;
    logic [31:0] E_MDU_B = 32'd0;
    logic        E_MDU_busy;
    logic [31:0] E_MDU_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDU_start(E_MDU_start),
        .E_MDU_op   (E_MDU_op),
        .E_MDU_A    (E_MDU_A),
        .E_MDU_B    (E_MDU_B),
        .E_MDU_busy (E_MDU_busy),
        .E_MDU_out  (E_MDU_out)
    );

    always #5 clk = ~clk;

    // Reference result: {ok, hi, lo} from plain 64-bit integer arithmetic.
    function automatic logic [64:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          sp;
        longint unsigned up;
        longint          sq;
        longint          sr;
        case (op)
            3'd0: begin sp = sa * sb; return {1'b1, sp[63:0]}; end
            3'd1: begin up = ua * ub; return {1'b1, up[63:0]}; end
            3'd2: begin
                if (b == 32'd0) return 65'd0;
                sq = sa / sb;
                sr = sa % sb;
                return {1'b1, sr[31:0], sq[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return 65'd0;
                up = ua / ub;
                sp = longint'(ua % ub);
                return {1'b1, sp[31:0], up[31:0]};
            end
            default: return 65'd0;
        endcase
    endfunction

    int unsigned m_rem = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_a = 32'd0, m_b = 32'd0;
    logic [2:0]  m_op = 3'd0;
    logic [64:0] m_res;

    always @(posedge clk) begin
        if (!reset) begin
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
            m_rem <= 0;
        end else if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_res = ref_mdu(m_op, m_a, m_b);
                if (m_res[64]) begin
                    m_hi <= m_res[63:32];
                    m_lo <= m_res[31:0];
                end
            end
        end else if (E_MDU_start && E_MDU_op <= 3'd3) begin
            m_a   <= E_MDU_A;
            m_b   <= E_MDU_B;
            m_op  <= E_MDU_op;
            m_rem <= (E_MDU_op >= 3'd2) ? DC : MC;
        end else if (E_MDU_op == MDU_MTHI) begin
            m_hi <= E_MDU_A;
        end else if (E_MDU_op == MDU_MTLO) begin
            m_lo <= E_MDU_A;
        end
    end

    logic        exp_busy;
    logic [31:0] exp_out;

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            exp_busy = (m_rem != 0);
            exp_out  = (E_MDU_op == MDU_MFHI) ? m_hi :
                       (E_MDU_op == MDU_MFLO) ? m_lo : 32'd0;
            checks++;
            if (E_MDU_busy !== exp_busy) begin
                errors++;
                $display("FAIL model_busy t=%0t: got %b expected %b", $time, E_MDU_busy,
                         exp_busy);
            end
            checks++;
            if (E_MDU_out !== exp_out) begin
                errors++;
                $display("FAIL model_out t=%0t op=%0d: got %h expected %h", $time, E_MDU_op,
                         E_MDU_out, exp_out);
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        E_MDU_start = s;
        E_MDU_op    = op;
        E_MDU_A     = a;
        E_MDU_B     = b;
    endtask

    task automatic idle();
        drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            #2;
            if (E_MDU_busy) n++;
            else break;
        end
    endtask

    task automatic read_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        drive(1'b0, MDU_MFHI, 32'd0, 32'd0);
        #2 check32({name, "_hi"}, E_MDU_out, hi);
        drive(1'b0, MDU_MFLO, 32'd0, 32'd0);
        #2 check32({name, "_lo"}, E_MDU_out, lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int n2;
        repeat (2) idle();
        reset = 1'b1;
        chk_en = 1'b1;
        idle();
        #2 check32("reset_busy", 32'(E_MDU_busy), 32'd0);
        read_hilo("reset", 32'd0, 32'd0);

        drive(1'b1, MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        count_busy(n);
        check32("mult_busy_len", 32'(n), 32'd5);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        drive(1'b1, MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
        count_busy(n);
        check32("multu_busy_len", 32'(n), 32'd5);
        read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        drive(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        check32("div_busy_len", 32'(n), 32'd10);
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        drive(1'b1, MDU_DIVU, 32'd7, 32'd0);
        count_busy(n);
        check32("divu0_busy_len", 32'(n), 32'd10);
        read_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        drive(1'b0, MDU_MTHI, 32'h1234_5678, 32'd0);
        drive(1'b0, MDU_MFHI, 32'd0, 32'd0);
        #2 check32("mthi", E_MDU_out, 32'h1234_5678);

        drive(1'b1, MDU_DIVU, 32'd7, 32'd0);
        idle();
        drive(1'b0, MDU_MTLO, 32'hDEAD_BEEF, 32'd0);
        count_busy(n);
        read_hilo("mtlo_busy", 32'h1234_5678, 32'hFFFF_FFFD);

        drive(1'b1, MDU_MULT, 32'd6, 32'd7);
        idle();
        idle();
        drive(1'b1, MDU_DIV, 32'd100, 32'd7);
        #2 n = E_MDU_busy ? 3 : 0;
        count_busy(n2);
        check32("restart_busy_len", 32'(n + n2), 32'd5);
        read_hilo("restart", 32'd0, 32'd42);

        drive(1'b1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        read_hilo("div_ovf", 32'd0, 32'h8000_0000);

        drive(1'b0, MDU_MTHI, 32'h1234_5678, 32'd0);
        drive(1'b1, MDU_DIV, 32'd100, 32'd3);
        repeat (6) idle();
        idle();
        reset = 1'b0;
        idle();
        reset = 1'b1;
        #2 check32("midreset_busy", 32'(E_MDU_busy), 32'd0);
        repeat (12) idle();
        read_hilo("midreset", 32'd0, 32'd0);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 3) == 0, 3'($urandom % 8), pick(), pick());
            reset = (($urandom % 64) != 0);
        end
        reset = 1'b1;
        repeat (12) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
